// File: rtl/hazard_pkg.sv
// Shared opcode constants, FSM encoding and register-match helpers for the
// ID-stage hazard detection unit.
package hazard_pkg;

  localparam int unsigned OpW  = 6;
  localparam int unsigned RegW = 5;
  localparam int unsigned CntW = 16;

  localparam logic [OpW-1:0] OpRType = 6'b000000;
  localparam logic [OpW-1:0] OpBeq   = 6'b000100;
  localparam logic [OpW-1:0] OpBne   = 6'b000101;
  localparam logic [OpW-1:0] OpSw    = 6'b101011;
  localparam logic [OpW-1:0] OpLw    = 6'b100011;
  localparam logic [OpW-1:0] OpJ     = 6'b000010;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StStall2 = 1'b1
  } state_e;

  // Instructions whose Rt field is a source operand rather than a destination.
  function automatic logic uses_rt(input logic [OpW-1:0] op);
    return (op == OpRType) || (op == OpBeq) || (op == OpBne) || (op == OpSw);
  endfunction

  function automatic logic is_branch(input logic [OpW-1:0] op);
    return (op == OpBeq) || (op == OpBne);
  endfunction

  // $0 is hardwired to zero, so a write to it can never create a dependency.
  function automatic logic reg_match(input logic [RegW-1:0] w,
                                     input logic [RegW-1:0] rs,
                                     input logic [RegW-1:0] rt,
                                     input logic            use_rt);
    return (w != '0) && ((w == rs) || (use_rt && (w == rt)));
  endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit saturating event counter with synchronous clear (clear wins).
module sat_cnt16
  import hazard_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            inc,
  output logic [CntW-1:0] q
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/hazard_detect.sv
// ID-stage hazard unit: stalls on load-use and branch-operand hazards, flushes
// IF/ID on taken branches and jumps, and counts stall and flush cycles.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     id_instru,
  input  logic            c_id_ex_MemRead,
  input  logic            c_id_ex_RegWrite,
  input  logic [RegW-1:0] id_ex_wReg,
  input  logic            c_ex_mem_MemRead,
  input  logic [RegW-1:0] ex_mem_wReg,
  input  logic            c_branch_taken,
  input  logic            stat_clr,
  output logic            c_pc_write,
  output logic            c_if_id_write,
  output logic            c_id_ex_bubble,
  output logic            c_if_id_flush,
  output logic [CntW-1:0] stall_cnt,
  output logic [CntW-1:0] flush_cnt
);

  logic [OpW-1:0]  opcode;
  logic [RegW-1:0] rs, rt;
  logic            unused_imm;

  assign opcode     = id_instru[31:26];
  assign rs         = id_instru[25:21];
  assign rt         = id_instru[20:16];
  assign unused_imm = ^id_instru[15:0];

  logic use_rt, br, jmp;
  logic match_ex, match_mem;
  logic hz_load_use, hz_alu_br, hz_ld_br_ex, hz_ld_br_mem, hz_any;

  assign use_rt    = uses_rt(opcode);
  assign br        = is_branch(opcode);
  assign jmp       = (opcode == OpJ);
  assign match_ex  = reg_match(id_ex_wReg, rs, rt, use_rt);
  assign match_mem = reg_match(ex_mem_wReg, rs, rt, use_rt);

  assign hz_load_use  = c_id_ex_MemRead & match_ex;
  assign hz_alu_br    = br & c_id_ex_RegWrite & ~c_id_ex_MemRead & match_ex;
  assign hz_ld_br_ex  = br & c_id_ex_MemRead & match_ex;
  assign hz_ld_br_mem = br & c_ex_mem_MemRead & match_mem;
  assign hz_any       = hz_load_use | hz_alu_br | hz_ld_br_ex | hz_ld_br_mem;

  state_e state_q, state_d;
  logic   stall_raw;

  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall_raw = hz_any;
        // A load feeding a branch from EX needs a second bubble.
        if (hz_ld_br_ex) begin
          state_d = StStall2;
        end
      end
      StStall2: begin
        stall_raw = 1'b1;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  logic stall, flush;

  // Outputs are forced to the free-running values while reset is held.
  // Branch outcome is stale during a stall, so stall masks flush.
  assign stall = rst_n & stall_raw;
  assign flush = rst_n & ~stall_raw & ((br & c_branch_taken) | jmp);

  assign c_pc_write     = ~stall;
  assign c_if_id_write  = ~stall;
  assign c_id_ex_bubble = stall;
  assign c_if_id_flush  = flush;

  sat_cnt16 u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stat_clr),
    .inc   (stall),
    .q     (stall_cnt)
  );

  sat_cnt16 u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stat_clr),
    .inc   (flush),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_detect.sv
// Directed bench for hazard_detect: stall/flush control and saturating counters.
module tb_hazard_detect;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpAddi = 6'b001000;

  // {pc_write, if_id_write, id_ex_bubble, if_id_flush}
  localparam logic [3:0] CtlRun   = 4'b1100;
  localparam logic [3:0] CtlStall = 4'b0010;
  localparam logic [3:0] CtlFlush = 4'b1101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_instru;
  logic        c_id_ex_MemRead, c_id_ex_RegWrite, c_ex_mem_MemRead;
  logic [4:0]  id_ex_wReg, ex_mem_wReg;
  logic        c_branch_taken, stat_clr;
  logic        c_pc_write, c_if_id_write, c_id_ex_bubble, c_if_id_flush;
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0]  ctl;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_stall, exp_flush;

  always #5 clk = ~clk;

  hazard_detect dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_instru        (id_instru),
    .c_id_ex_MemRead  (c_id_ex_MemRead),
    .c_id_ex_RegWrite (c_id_ex_RegWrite),
    .id_ex_wReg       (id_ex_wReg),
    .c_ex_mem_MemRead (c_ex_mem_MemRead),
    .ex_mem_wReg      (ex_mem_wReg),
    .c_branch_taken   (c_branch_taken),
    .stat_clr         (stat_clr),
    .c_pc_write       (c_pc_write),
    .c_if_id_write    (c_if_id_write),
    .c_id_ex_bubble   (c_id_ex_bubble),
    .c_if_id_flush    (c_if_id_flush),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  assign ctl = {c_pc_write, c_if_id_write, c_id_ex_bubble, c_if_id_flush};

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt);
    return {op, rs, rt, 16'h1234};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic ex_mr, input logic ex_rw,
                       input logic [4:0] ex_w, input logic mem_mr, input logic [4:0] mem_w,
                       input logic taken);
    id_instru        = ins;
    c_id_ex_MemRead  = ex_mr;
    c_id_ex_RegWrite = ex_rw;
    id_ex_wReg       = ex_w;
    c_ex_mem_MemRead = mem_mr;
    ex_mem_wReg      = mem_w;
    c_branch_taken   = taken;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    stat_clr = 1'b0;
    drive(mk(OpBeq, 5'd2, 5'd4), 1'b1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1);
    #3;
    checks++;
    if (ctl !== CtlRun) begin
      errors++; $display("FAIL reset_ctl got %b want %b", ctl, CtlRun);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ctl !== CtlRun) begin
      errors++; $display("FAIL reset_ctl_held got %b want %b", ctl, CtlRun);
    end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %h/%h want 0/0", stall_cnt, flush_cnt);
    end
    drive(mk(OpR, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    rst_n     = 1'b1;
    exp_stall = 16'd0;
    exp_flush = 16'd0;
  endtask

  task automatic test_load_use;
    tick;
    drive(mk(OpR, 5'd2, 5'd4), 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== CtlStall) begin
      errors++; $display("FAIL lu_stall got %b want %b", ctl, CtlStall);
    end
    tick;
    drive(mk(OpR, 5'd2, 5'd4), 1'b0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0);
    exp_stall = exp_stall + 16'd1;
    @(negedge clk);
    checks++;
    if (ctl !== CtlRun) begin
      errors++; $display("FAIL lu_release got %b want %b", ctl, CtlRun);
    end
    checks++;
    if (stall_cnt !== exp_stall) begin
      errors++; $display("FAIL lu_stall_cnt got %0d want %0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_load_branch_ex;
    tick;
    drive(mk(OpBeq, 5'd5, 5'd6), 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1);
    @(negedge clk);
    checks++;
    if (ctl !== CtlStall) begin
      errors++; $display("FAIL lbe_stall1 got %b want %b", ctl, CtlStall);
    end
    // No live hazard on the inputs: only the FSM can hold the second stall.
    tick;
    drive(mk(OpBeq, 5'd5, 5'd6), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    @(negedge clk);
    checks++;
    if (ctl !== CtlStall) begin
      errors++; $display("FAIL lbe_stall2 got %b want %b", ctl, CtlStall);
    end
    tick;
    @(negedge clk);
    checks++;
    if (ctl !== CtlFlush) begin
      errors++; $display("FAIL lbe_flush got %b want %b", ctl, CtlFlush);
    end
    exp_stall = exp_stall + 16'd2;
    checks++;
    if (stall_cnt !== exp_stall) begin
      errors++; $display("FAIL lbe_stall_cnt got %0d want %0d", stall_cnt, exp_stall);
    end
    tick;
    drive(mk(OpR, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    exp_flush = exp_flush + 16'd1;
    @(negedge clk);
    checks++;
    if (ctl !== CtlRun || flush_cnt !== exp_flush) begin
      errors++; $display("FAIL lbe_after got %b/%0d want %b/%0d", ctl, flush_cnt, CtlRun,
                         exp_flush);
    end
  endtask

  task automatic test_alu_branch;
    tick;
    drive(mk(OpBne, 5'd1, 5'd7), 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1);
    @(negedge clk);
    checks++;
    if (ctl !== CtlStall) begin
      errors++; $display("FAIL ab_stall got %b want %b", ctl, CtlStall);
    end
    tick;
    drive(mk(OpBne, 5'd1, 5'd7), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    exp_stall = exp_stall + 16'd1;
    @(negedge clk);
    checks++;
    if (ctl !== CtlFlush) begin
      errors++; $display("FAIL ab_flush got %b want %b", ctl, CtlFlush);
    end
    tick;
    drive(mk(OpR, 5'd7, 5'd7), 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
    exp_flush = exp_flush + 16'd1;
    @(negedge clk);
    checks++;
    if (ctl !== CtlRun) begin
      errors++; $display("FAIL ab_nonbranch got %b want %b", ctl, CtlRun);
    end
    checks++;
    if (flush_cnt !== exp_flush || stall_cnt !== exp_stall) begin
      errors++; $display("FAIL ab_cnt got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt,
                         exp_stall, exp_flush);
    end
  endtask

  task automatic test_zero_and_rt;
    tick;
    drive(mk(OpR, 5'd0, 5'd0), 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== CtlRun) begin
      errors++; $display("FAIL zero_reg got %b want %b", ctl, CtlRun);
    end
    tick;
    drive(mk(OpAddi, 5'd8, 5'd9), 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== CtlStall) begin
      errors++; $display("FAIL addi_rs got %b want %b", ctl, CtlStall);
    end
    tick;
    drive(mk(OpAddi, 5'd9, 5'd8), 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== CtlRun) begin
      errors++; $display("FAIL addi_rt_dest got %b want %b", ctl, CtlRun);
    end
    tick;
    drive(mk(OpSw, 5'd9, 5'd8), 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== CtlStall) begin
      errors++; $display("FAIL sw_rt got %b want %b", ctl, CtlStall);
    end
    tick;
    drive(mk(OpBeq, 5'd0, 5'd0), 1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
    exp_stall = exp_stall + 16'd2;
    @(negedge clk);
    checks++;
    if (ctl !== CtlRun) begin
      errors++; $display("FAIL zero_branch got %b want %b", ctl, CtlRun);
    end
    checks++;
    if (stall_cnt !== exp_stall) begin
      errors++; $display("FAIL zr_stall_cnt got %0d want %0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_mem_and_jump;
    tick;
    drive(mk(OpBeq, 5'd1, 5'd3), 1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1);
    @(negedge clk);
    checks++;
    if (ctl !== CtlStall) begin
      errors++; $display("FAIL lbm_stall got %b want %b", ctl, CtlStall);
    end
    tick;
    drive(mk(OpBeq, 5'd1, 5'd3), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    @(negedge clk);
    checks++;
    if (ctl !== CtlFlush) begin
      errors++; $display("FAIL lbm_flush got %b want %b", ctl, CtlFlush);
    end
    tick;
    drive(mk(OpR, 5'd1, 5'd3), 1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== CtlRun) begin
      errors++; $display("FAIL lbm_nonbranch got %b want %b", ctl, CtlRun);
    end
    tick;
    drive(mk(OpJ, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== CtlFlush) begin
      errors++; $display("FAIL jump got %b want %b", ctl, CtlFlush);
    end
    tick;
    drive(mk(OpR, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    @(negedge clk);
    checks++;
    if (ctl !== CtlRun) begin
      errors++; $display("FAIL taken_nonbranch got %b want %b", ctl, CtlRun);
    end
    tick;
    drive(mk(OpBeq, 5'd1, 5'd2), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== CtlRun) begin
      errors++; $display("FAIL not_taken got %b want %b", ctl, CtlRun);
    end
    exp_stall = exp_stall + 16'd1;
    exp_flush = exp_flush + 16'd2;
    checks++;
    if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
      errors++; $display("FAIL mj_cnt got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt,
                         exp_stall, exp_flush);
    end
  endtask

  task automatic test_reset_mid_stall;
    tick;
    drive(mk(OpBeq, 5'd5, 5'd6), 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
    tick;
    drive(mk(OpR, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    checks++;
    if (ctl !== CtlStall) begin
      errors++; $display("FAIL rms_in_stall2 got %b want %b", ctl, CtlStall);
    end
    rst_n = 1'b0;
    drive(mk(OpR, 5'd2, 5'd4), 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0);
    #1;
    checks++;
    if (ctl !== CtlRun) begin
      errors++; $display("FAIL rms_reset_out got %b want %b", ctl, CtlRun);
    end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL rms_reset_cnt got %h/%h want 0/0", stall_cnt, flush_cnt);
    end
    drive(mk(OpR, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ctl !== CtlRun) begin
      errors++; $display("FAIL rms_release got %b want %b", ctl, CtlRun);
    end
    tick;
    @(negedge clk);
    checks++;
    if (ctl !== CtlRun || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL rms_after got %b/%0d want %b/0", ctl, stall_cnt, CtlRun);
    end
  endtask

  task automatic test_counters;
    tick;
    drive(mk(OpJ, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick;
    drive(mk(OpR, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    stat_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (flush_cnt !== 16'd1) begin
      errors++; $display("FAIL pre_clr got %0d want 1", flush_cnt);
    end
    tick;
    stat_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (flush_cnt !== 16'd0) begin
      errors++; $display("FAIL clr_flush got %0d want 0", flush_cnt);
    end
    tick;
    drive(mk(OpR, 5'd2, 5'd4), 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0);
    repeat (65535) @(posedge clk);
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_reach got %h want ffff", stall_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold got %h want ffff", stall_cnt);
    end
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL clr_priority got %h want 0", stall_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'd1) begin
      errors++; $display("FAIL after_clr got %h want 1", stall_cnt);
    end
    drive(mk(OpR, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_load_use;
    test_load_branch_ex;
    test_alu_branch;
    test_zero_and_rt;
    test_mem_and_jump;
    test_reset_mid_stall;
    test_counters;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
